// File: rtl/capture_engine_gen2_pkg.sv
// Shared encodings for the capture engine: FSM states and trigger modes.
package logic_hamr_cap_pkg;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARMED = 3'd1;
   localparam logic [2:0] ST_XFER  = 3'd2;
   localparam logic [2:0] ST_POST  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [1:0] TRIG_RISE   = 2'd0;
   localparam logic [1:0] TRIG_FALL   = 2'd1;
   localparam logic [1:0] TRIG_EITHER = 2'd2;
   localparam logic [1:0] TRIG_PAT    = 2'd3;
endpackage

// File: rtl/capture_engine_gen2_pretrig_ring.sv
// Pre-trigger circular buffer: saturating fill count and a read pointer that
// can jump to the oldest of the last N written entries.
module pretrig_ring #(
   parameter  int NUM_CH    = 8,
   parameter  int PRE_DEPTH = 16,
   localparam int PW        = $clog2(PRE_DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              wr_en_i,
   input  logic [NUM_CH-1:0] wr_data_i,
   input  logic [PW:0]       sat_i,
   input  logic              rd_load_i,
   input  logic [PW-1:0]     rd_n_i,
   input  logic              rd_adv_i,
   output logic [PW:0]       count_o,
   output logic [NUM_CH-1:0] rd_data_o
);
   logic [PRE_DEPTH-1:0][NUM_CH-1:0] mem_q;
   logic [PW-1:0]                    wp_q, rp_q;
   logic [PW:0]                      cnt_q;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wp_q] <= wr_data_i;
   end

   // rd_n is taken mod PRE_DEPTH: a full ring's oldest entry sits at wp itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else if (clr_i) begin
         wp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_en_i) begin
            wp_q <= wp_q + PW'(1);
            if (cnt_q < sat_i) cnt_q <= cnt_q + (PW+1)'(1);
         end
         if (rd_load_i)     rp_q <= wp_q - rd_n_i;
         else if (rd_adv_i) rp_q <= rp_q + PW'(1);
      end
   end

   assign count_o   = cnt_q;
   assign rd_data_o = mem_q[rp_q];
endmodule

// File: rtl/capture_engine_gen2.sv
// Triggered capture engine: pre-trigger ring, trigger detect, and a single
// outstanding-write stream of pre/trigger/post samples into SDRAM.
module capture_engine_gen2
   import logic_hamr_cap_pkg::*;
#(
   parameter int NUM_CH    = 8,
   parameter int ADDR_W    = 13,
   parameter int PRE_DEPTH = 16,
   parameter int CNT_W     = 13
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         arm,
   input  logic                         abort,
   input  logic                         force_trig,
   input  logic [NUM_CH-1:0]            probe_input,
   input  logic                         sample_strobe,
   input  logic [1:0]                   cfg_trig_mode,
   input  logic [$clog2(NUM_CH)-1:0]    cfg_trig_ch,
   input  logic [NUM_CH-1:0]            cfg_pat_mask,
   input  logic [NUM_CH-1:0]            cfg_pat_value,
   input  logic [$clog2(PRE_DEPTH):0]   cfg_pre,
   input  logic [CNT_W-1:0]             cfg_total,
   input  logic [ADDR_W-1:0]            cfg_base,
   output logic                         armed,
   output logic                         captured,
   output logic                         overrun,
   output logic [CNT_W-1:0]             samples_written,
   output logic [CNT_W-1:0]             trig_index,
   output logic                         pause_refresh,
   output logic [2:0]                   state_dbg,
   output logic                         sdram_wr_req,
   output logic [ADDR_W-1:0]            sdram_wr_addr,
   output logic [NUM_CH-1:0]            sdram_wr_data,
   input  logic                         sdram_wr_ready
);
   localparam int CW  = $clog2(NUM_CH);
   localparam int PW  = $clog2(PRE_DEPTH);
   localparam int PW1 = PW + 1;

   logic [2:0]        state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic [NUM_CH-1:0] mask_q, mask_d, val_q, val_d;
   logic [PW:0]       pre_q, pre_d, pre_eff_q, pre_eff_d, xcnt_q, xcnt_d;
   logic [CNT_W-1:0]  total_q, total_d, rem_q, rem_d, swr_q, swr_d, tidx_q, tidx_d;
   logic [ADDR_W-1:0] base_q, base_d, widx_q, widx_d, addr_q, addr_d;
   logic [NUM_CH-1:0] prev_q, prev_d, trig_q, trig_d, hold_q, hold_d, data_q, data_d;
   logic              prev_vld_q, prev_vld_d, prev_match_q, prev_match_d;
   logic              force_q, force_d, hold_v_q, hold_v_d, req_q, req_d, ovr_q, ovr_d;

   logic              ring_clr, ring_wr, rd_load, rd_adv;
   logic [PW:0]       ring_cnt, pre_eff, pre_clamp;
   logic [NUM_CH-1:0] ring_rd, issue_data;
   logic              acc, issue_ok, issue, drain, match, cond, fire;
   logic [CNT_W-1:0]  pre_ext, post_len;

   pretrig_ring #(.NUM_CH(NUM_CH), .PRE_DEPTH(PRE_DEPTH)) u_ring (
      .clk(clk), .rst_n(rst_n), .clr_i(ring_clr), .wr_en_i(ring_wr),
      .wr_data_i(probe_input), .sat_i(pre_q), .rd_load_i(rd_load),
      .rd_n_i(pre_eff[PW-1:0]), .rd_adv_i(rd_adv),
      .count_o(ring_cnt), .rd_data_o(ring_rd)
   );

   assign acc       = req_q && sdram_wr_ready;
   assign issue_ok  = !req_q || acc;
   assign pre_clamp = (cfg_pre > PW1'(PRE_DEPTH)) ? PW1'(PRE_DEPTH) : cfg_pre;
   assign pre_eff   = (ring_cnt < pre_q) ? ring_cnt : pre_q;
   assign pre_ext   = CNT_W'(pre_eff);
   assign post_len  = (total_q > pre_ext) ? (total_q - pre_ext) : CNT_W'(1);
   assign match     = ((probe_input & mask_q) == (val_q & mask_q));

   // Edge modes need a valid previous sample; pattern mode fires on entry into the match.
   always_comb begin
      cond = 1'b0;
      case (mode_q)
         TRIG_RISE:   cond = prev_vld_q && !prev_q[ch_q] &&  probe_input[ch_q];
         TRIG_FALL:   cond = prev_vld_q &&  prev_q[ch_q] && !probe_input[ch_q];
         TRIG_EITHER: cond = prev_vld_q && (prev_q[ch_q] != probe_input[ch_q]);
         default:     cond = match && !(prev_vld_q && prev_match_q);
      endcase
      fire = force_q || force_trig || (cond && (ring_cnt >= pre_q));
   end

   always_comb begin
      state_d = state_q;   mode_d = mode_q;   ch_d = ch_q;       mask_d = mask_q;
      val_d = val_q;       pre_d = pre_q;     total_d = total_q; base_d = base_q;
      prev_d = prev_q;     prev_vld_d = prev_vld_q;  prev_match_d = prev_match_q;
      force_d = force_q;   trig_d = trig_q;   pre_eff_d = pre_eff_q;  xcnt_d = xcnt_q;
      rem_d = rem_q;       hold_v_d = hold_v_q;  hold_d = hold_q;  req_d = req_q;
      addr_d = addr_q;     data_d = data_q;   widx_d = widx_q;   ovr_d = ovr_q;
      swr_d = swr_q;       tidx_d = tidx_q;
      ring_clr = 1'b0;  ring_wr = 1'b0;  rd_load = 1'b0;  rd_adv = 1'b0;
      issue = 1'b0;     issue_data = '0; drain = 1'b0;

      if (acc) swr_d = swr_q + CNT_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: if (arm) begin
            mode_d = cfg_trig_mode;  ch_d = cfg_trig_ch;  mask_d = cfg_pat_mask;
            val_d = cfg_pat_value;   pre_d = pre_clamp;   total_d = cfg_total;
            base_d = cfg_base;       ring_clr = 1'b1;     prev_vld_d = 1'b0;
            ovr_d = 1'b0;  swr_d = '0;  tidx_d = '0;  widx_d = '0;
            force_d = 1'b0;  hold_v_d = 1'b0;  state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (sample_strobe) begin
               prev_d = probe_input;  prev_vld_d = 1'b1;  prev_match_d = match;
               if (fire) begin
                  trig_d = probe_input;  pre_eff_d = pre_eff;  tidx_d = pre_ext;
                  rem_d = post_len - CNT_W'(1);  xcnt_d = '0;  rd_load = 1'b1;
                  force_d = 1'b0;  state_d = ST_XFER;
               end else begin
                  ring_wr = 1'b1;
               end
            end else if (force_trig) begin
               force_d = 1'b1;
            end
         end
         ST_XFER: if (issue_ok) begin
            issue = 1'b1;
            if (xcnt_q < pre_eff_q) begin
               issue_data = ring_rd;  rd_adv = 1'b1;  xcnt_d = xcnt_q + PW1'(1);
            end else begin
               issue_data = trig_q;   state_d = ST_POST;
            end
         end
         ST_POST: begin
            drain = hold_v_q && issue_ok;
            if (drain) begin
               issue = 1'b1;  issue_data = hold_q;  hold_v_d = 1'b0;
            end
            // A full holding register drops the sample but still consumes window time.
            if (sample_strobe && (rem_q != '0)) begin
               rem_d = rem_q - CNT_W'(1);
               if (!hold_v_q || drain) begin
                  hold_v_d = 1'b1;  hold_d = probe_input;
               end else begin
                  ovr_d = 1'b1;
               end
            end
            if ((rem_q == '0) && !hold_v_q && issue_ok) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (issue) begin
         req_d = 1'b1;  addr_d = base_q + widx_q;  data_d = issue_data;
         widx_d = widx_q + ADDR_W'(1);
      end else if (acc) begin
         req_d = 1'b0;
      end

      if (abort) begin
         state_d = ST_IDLE;  req_d = 1'b0;  ovr_d = 1'b0;  force_d = 1'b0;
         hold_v_d = 1'b0;    ring_clr = 1'b0;  ring_wr = 1'b0;  rd_load = 1'b0;
         rd_adv = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;  mode_q <= '0;  ch_q <= '0;  mask_q <= '0;  val_q <= '0;
         pre_q <= '0;  total_q <= '0;  base_q <= '0;  prev_q <= '0;  prev_vld_q <= 1'b0;
         prev_match_q <= 1'b0;  force_q <= 1'b0;  trig_q <= '0;  pre_eff_q <= '0;
         xcnt_q <= '0;  rem_q <= '0;  hold_v_q <= 1'b0;  hold_q <= '0;  req_q <= 1'b0;
         addr_q <= '0;  data_q <= '0;  widx_q <= '0;  ovr_q <= 1'b0;  swr_q <= '0;
         tidx_q <= '0;
      end else begin
         state_q <= state_d;  mode_q <= mode_d;  ch_q <= ch_d;  mask_q <= mask_d;
         val_q <= val_d;  pre_q <= pre_d;  total_q <= total_d;  base_q <= base_d;
         prev_q <= prev_d;  prev_vld_q <= prev_vld_d;  prev_match_q <= prev_match_d;
         force_q <= force_d;  trig_q <= trig_d;  pre_eff_q <= pre_eff_d;
         xcnt_q <= xcnt_d;  rem_q <= rem_d;  hold_v_q <= hold_v_d;  hold_q <= hold_d;
         req_q <= req_d;  addr_q <= addr_d;  data_q <= data_d;  widx_q <= widx_d;
         ovr_q <= ovr_d;  swr_q <= swr_d;  tidx_q <= tidx_d;
      end
   end

   assign armed           = (state_q == ST_ARMED);
   assign captured        = (state_q == ST_DONE);
   assign overrun         = ovr_q;
   assign samples_written = swr_q;
   assign trig_index      = tidx_q;
   assign pause_refresh   = (state_q == ST_ARMED) || (state_q == ST_XFER) || (state_q == ST_POST);
   assign state_dbg       = state_q;
   assign sdram_wr_req    = req_q;
   assign sdram_wr_addr   = addr_q;
   assign sdram_wr_data   = data_q;
endmodule

// File: tb/tb_capture_engine_gen2.sv
// Scoreboarded directed bench for capture_engine_gen2: expected SDRAM writes
// are queued per capture and popped by an independent write monitor.
`timescale 1ns/1ps
module tb_capture_engine_gen2;
   localparam int NUM_CH = 8, ADDR_W = 13, PRE_DEPTH = 16, CNT_W = 13;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic              arm = 0, abort = 0, force_trig = 0, sample_strobe = 0;
   logic [7:0]        probe_input = '0, cfg_pat_mask = '0, cfg_pat_value = '0;
   logic [1:0]        cfg_trig_mode = '0;
   logic [2:0]        cfg_trig_ch = '0;
   logic [4:0]        cfg_pre = '0;
   logic [12:0]       cfg_total = '0, cfg_base = '0;
   logic              sdram_wr_ready = 1'b1;
   logic              armed, captured, overrun, pause_refresh, sdram_wr_req;
   logic [12:0]       samples_written, trig_index, sdram_wr_addr;
   logic [2:0]        state_dbg;
   logic [7:0]        sdram_wr_data;

   always #5 clk = ~clk;

   capture_engine_gen2 #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .PRE_DEPTH(PRE_DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .force_trig(force_trig),
      .probe_input(probe_input), .sample_strobe(sample_strobe),
      .cfg_trig_mode(cfg_trig_mode), .cfg_trig_ch(cfg_trig_ch),
      .cfg_pat_mask(cfg_pat_mask), .cfg_pat_value(cfg_pat_value),
      .cfg_pre(cfg_pre), .cfg_total(cfg_total), .cfg_base(cfg_base),
      .armed(armed), .captured(captured), .overrun(overrun),
      .samples_written(samples_written), .trig_index(trig_index),
      .pause_refresh(pause_refresh), .state_dbg(state_dbg),
      .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr),
      .sdram_wr_data(sdram_wr_data), .sdram_wr_ready(sdram_wr_ready)
   );

   typedef struct packed { logic [12:0] a; logic [7:0] d; } wr_t;
   wr_t        exp_q[$];
   wr_t        mon_e;
   int         n_cmp = 0, n_bad = 0;
   logic [7:0] stim [0:127];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Accepted writes sampled mid-cycle; inputs only change just after posedge.
   always @(negedge clk) begin
      if (rst_n && sdram_wr_req && sdram_wr_ready) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                     sdram_wr_addr, sdram_wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({sdram_wr_addr, sdram_wr_data} !== mon_e) begin
               n_bad++;
               $display("FAIL wr_beat: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                        sdram_wr_addr, sdram_wr_data, mon_e.a, mon_e.d);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic strobe(input logic [7:0] v);
      probe_input = v; sample_strobe = 1'b1; tick();
      sample_strobe = 1'b0; repeat (7) tick();
   endtask

   task automatic do_arm(input logic [1:0] md, input logic [2:0] ch, input logic [7:0] mk,
                         input logic [7:0] vl, input logic [4:0] pre, input logic [12:0] tot,
                         input logic [12:0] base);
      cfg_trig_mode = md; cfg_trig_ch = ch; cfg_pat_mask = mk; cfg_pat_value = vl;
      cfg_pre = pre; cfg_total = tot; cfg_base = base;
      arm = 1'b1; tick(); arm = 1'b0; tick();
   endtask

   task automatic push_win(input int base, input int first, input int n);
      wr_t w;
      for (int i = 0; i < n; i++) begin
         w.a = 13'(base + i); w.d = stim[first + i]; exp_q.push_back(w);
      end
   endtask

   task automatic wait_done(input string nm);
      int t = 0;
      while (!captured && t < 3000) begin tick(); t++; end
      chk({nm, "_captured"}, 64'(captured), 64'd1);
      chk({nm, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [63:0] all_out();
      return {9'd0, armed, captured, overrun, samples_written, trig_index, pause_refresh,
              state_dbg, sdram_wr_req, sdram_wr_addr, sdram_wr_data};
   endfunction

   initial begin
      wr_t w;
      repeat (2) tick();
      chk("reset_outputs", all_out(), 64'd0);
      rst_n = 1'b1; tick();

      // Rising edge on ch2 at strobe 10, ramp elsewhere.
      for (int k = 0; k < 94; k++) stim[k] = 8'((k & ~4) | ((k >= 10) ? 4 : 0));
      push_win(13'h100, 6, 88);
      do_arm(2'd0, 3'd2, 8'h00, 8'h00, 5'd4, 13'd88, 13'h100);
      chk("t1_armed", 64'({armed, pause_refresh, state_dbg}), 64'b11_001);
      for (int k = 0; k < 94; k++) strobe(stim[k]);
      wait_done("t1");
      chk("t1_samples", 64'(samples_written), 64'd88);
      chk("t1_trig_index", 64'(trig_index), 64'd4);
      chk("t1_status", 64'({armed, overrun, pause_refresh, state_dbg}), 64'b000_100);

      // Falling ch5: early edge at strobe 2 is ignored, strobe 12 triggers; address wraps.
      for (int k = 0; k < 28; k++)
         stim[k] = 8'((k & ~32) | (((k < 2) || (k >= 3 && k < 12)) ? 32 : 0));
      push_win(13'h1FF0, 8, 20);
      do_arm(2'd1, 3'd5, 8'h00, 8'h00, 5'd4, 13'd20, 13'h1FF0);
      for (int k = 0; k < 28; k++) begin
         strobe(stim[k]);
         if (k == 2) chk("t2_early_edge_ignored", 64'(state_dbg), 64'd1);
      end
      wait_done("t2");
      chk("t2_samples", 64'(samples_written), 64'd20);
      chk("t2_trig_index", 64'(trig_index), 64'd4);

      // Pattern low nibble 0x5: already matching at arm, fires on re-entry at strobe 7.
      for (int k = 0; k < 13; k++) stim[k] = 8'((k << 4) | ((k == 5 || k == 6) ? 3 : 5));
      push_win(13'h040, 3, 10);
      do_arm(2'd3, 3'd0, 8'h0F, 8'h05, 5'd4, 13'd10, 13'h040);
      for (int k = 0; k < 13; k++) begin
         strobe(stim[k]);
         if (k == 4) chk("t3_no_early_pattern", 64'(state_dbg), 64'd1);
      end
      wait_done("t3");
      chk("t3_trig_index", 64'(trig_index), 64'd4);
      chk("t3_samples", 64'(samples_written), 64'd10);

      // Forced trigger after two strobes with a larger requested pre-window.
      for (int k = 0; k < 12; k++) stim[k] = 8'(k << 1);
      push_win(13'h300, 0, 12);
      do_arm(2'd0, 3'd0, 8'h00, 8'h00, 5'd13, 13'd12, 13'h300);
      strobe(stim[0]); strobe(stim[1]);
      force_trig = 1'b1; tick(); force_trig = 1'b0; tick();
      for (int k = 2; k < 12; k++) strobe(stim[k]);
      wait_done("t4");
      chk("t4_trig_index", 64'(trig_index), 64'd2);
      chk("t4_samples", 64'(samples_written), 64'd12);

      // Ready stalls in POST: strobes 10 and 11 are dropped.
      for (int k = 0; k < 22; k++) stim[k] = 8'((k << 1) | ((k >= 4) ? 1 : 0));
      begin
         int j = 0;
         for (int k = 2; k < 22; k++) begin
            if (k != 10 && k != 11) begin
               w.a = 13'(13'h500 + j); w.d = stim[k]; exp_q.push_back(w); j++;
            end
         end
      end
      do_arm(2'd0, 3'd0, 8'h00, 8'h00, 5'd2, 13'd20, 13'h500);
      for (int k = 0; k < 22; k++) begin
         if (k == 8)  sdram_wr_ready = 1'b0;
         if (k == 12) sdram_wr_ready = 1'b1;
         strobe(stim[k]);
         if (k == 15) chk("t5_pause_in_post", 64'({pause_refresh, overrun}), 64'b11);
      end
      wait_done("t5");
      chk("t5_overrun", 64'(overrun), 64'd1);
      chk("t5_samples", 64'(samples_written), 64'd18);
      chk("t5_pause_done", 64'(pause_refresh), 64'd0);

      // Abort while XFER is stalled on ready.
      for (int k = 0; k < 6; k++) stim[k] = 8'((k << 1) | ((k >= 5) ? 1 : 0));
      do_arm(2'd0, 3'd0, 8'h00, 8'h00, 5'd4, 13'd8, 13'h600);
      for (int k = 0; k < 5; k++) strobe(stim[k]);
      sdram_wr_ready = 1'b0;
      strobe(stim[5]);
      chk("t6_xfer_stalled", 64'({state_dbg, sdram_wr_req}), 64'b010_1);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("t6_abort_idle", 64'({state_dbg, sdram_wr_req, armed, captured, overrun}), 64'd0);
      sdram_wr_ready = 1'b1; tick();

      // Clean capture after the abort.
      for (int k = 0; k < 7; k++) stim[k] = 8'(8'h40 | (k << 1) | ((k >= 3) ? 1 : 0));
      push_win(13'h700, 1, 6);
      do_arm(2'd0, 3'd0, 8'h00, 8'h00, 5'd2, 13'd6, 13'h700);
      for (int k = 0; k < 7; k++) strobe(stim[k]);
      wait_done("t7");
      chk("t7_overrun", 64'(overrun), 64'd0);
      chk("t7_samples", 64'(samples_written), 64'd6);
      chk("t7_trig_index", 64'(trig_index), 64'd2);

      // Reset pulse while in POST.
      for (int k = 0; k < 7; k++) stim[k] = 8'(8'h80 | (k << 1) | ((k >= 3) ? 1 : 0));
      push_win(13'h780, 1, 6);
      do_arm(2'd0, 3'd0, 8'h00, 8'h00, 5'd2, 13'd30, 13'h780);
      for (int k = 0; k < 7; k++) strobe(stim[k]);
      chk("t8_in_post", 64'(state_dbg), 64'd3);
      chk("t8_queue_empty", 64'(exp_q.size()), 64'd0);
      rst_n = 1'b0; tick();
      chk("t8_reset_outputs", all_out(), 64'd0);
      rst_n = 1'b1; repeat (2) tick();
      chk("t8_after_reset", all_out(), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
